// File: rtl/dct_mac_acc.sv
// dct_mac_acc: three-stage signed multiply-accumulate for DCT-style dot products.
// Each TERMS consecutive accepted (din, coef) pairs produce one signed result.
//
// Ports:
//   clk        clock, all flops rising-edge
//   rst        asynchronous active-low reset
//   ena        global clock enable
//   dclr       synchronous abort of the current block (qualified by ena)
//   in_valid   sample/coefficient pair present
//   in_ready   pair accepted when in_valid && in_ready
//   din        signed sample, DWIDTH bits
//   coef       signed coefficient, CWIDTH bits
//   out_valid  result present; held until out_ready
//   out_ready  result consumed when out_valid && out_ready
//   dout       signed result, OWIDTH bits
//
// Build option: define DCT_MAC_SAT_EN to saturate the wide result into OWIDTH
// bits; otherwise dout is the low OWIDTH bits (wrap).

module dct_mac_acc #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 16,
  parameter int TERMS  = 8,
  parameter int OWIDTH = 12,
  localparam int PWIDTH = DWIDTH + CWIDTH,
  localparam int RWIDTH = PWIDTH + $clog2(TERMS),
  localparam int CNTW   = $clog2(TERMS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     dclr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DWIDTH-1:0] din,
  input  logic signed [CWIDTH-1:0] coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OWIDTH-1:0] dout
);

  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(TERMS - 1);

  logic                     advance;
  logic                     clr;
  logic [CNTW-1:0]          cnt;
  // [0] = S1 operand stage, [1] = S2 product stage
  logic [1:0]               vld_pipe;
  logic [1:0]               last_pipe;
  logic signed [DWIDTH-1:0] d1;
  logic signed [CWIDTH-1:0] c1;
  logic signed [PWIDTH-1:0] mult_res;
  logic signed [RWIDTH-1:0] acc;
  logic signed [RWIDTH-1:0] res;
  logic signed [RWIDTH-1:0] mult_ext;

  // A held result blocks the whole pipe so nothing is overwritten.
  assign advance  = ena && !(out_valid && !out_ready);
  assign in_ready = advance;
  assign clr      = ena && dclr;
  assign mult_ext = RWIDTH'(mult_res);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      d1        <= '0;
      c1        <= '0;
      mult_res  <= '0;
      acc       <= '0;
      res       <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      cnt       <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (advance) begin
        vld_pipe  <= {vld_pipe[0], in_valid};
        last_pipe <= {last_pipe[0], in_valid && (cnt == LAST_CNT)};
        if (in_valid) begin
          d1  <= din;
          c1  <= coef;
          cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end
        if (vld_pipe[0])
          mult_res <= PWIDTH'(d1) * PWIDTH'(c1);
        if (vld_pipe[1]) begin
          if (last_pipe[1]) begin
            // Close the block and restart from zero in the same edge, so the
            // next block's first product can follow without a gap.
            res <= acc + mult_ext;
            acc <= '0;
          end else begin
            acc <= acc + mult_ext;
          end
        end
      end
      // A completing block in the handshake cycle reloads instead of clearing.
      if (advance && vld_pipe[1] && last_pipe[1])
        out_valid <= 1'b1;
      else if (out_valid && out_ready)
        out_valid <= 1'b0;
    end
  end

`ifdef DCT_MAC_SAT_EN
  localparam logic signed [RWIDTH-1:0] OMAX = RWIDTH'((64'sd1 <<< (OWIDTH - 1)) - 64'sd1);
  localparam logic signed [RWIDTH-1:0] OMIN = RWIDTH'(-(64'sd1 <<< (OWIDTH - 1)));

  always_comb begin
    dout = res[OWIDTH-1:0];
    if (res > OMAX)
      dout = OMAX[OWIDTH-1:0];
    else if (res < OMIN)
      dout = OMIN[OWIDTH-1:0];
  end
`else
  assign dout = res[OWIDTH-1:0];
`endif

endmodule

// File: doc/dct_mac_acc.md
DCT_MAC_ACC -- requirements
Module: dct_mac_acc

Interface
REQ-001 Parameter DWIDTH, default 8, signed sample width.
REQ-002 Parameter CWIDTH, default 16, signed coefficient width.
REQ-003 Parameter TERMS, default 8, products per result; power of two, ≥2.
REQ-004 Parameter OWIDTH, default 12, signed output width.
REQ-005 Derived RWIDTH = DWIDTH+CWIDTH+log2(TERMS), internal accumulator width (27 at defaults).
REQ-006 Port list:
  - clk  in  1  clock; single clock domain, all flops rising-edge.
  - rst  in  1  asynchronous active-low reset.
  - ena  in  1  global clock enable.
  - dclr  in  1  synchronous abort/clear of the current block.
  - in_valid  in  1  sample/coefficient pair present.
  - in_ready  out  1  pair accepted when in_valid && in_ready.
  - din  in  DWIDTH  signed sample.
  - coef  in  CWIDTH  signed coefficient.
  - out_valid  out  1  result present.
  - out_ready  in  1  result consumed when out_valid && out_ready.
  - dout  out  OWIDTH  signed result.

Function
REQ-007 advance = ena && !(out_valid && !out_ready); in_ready SHALL equal advance.
REQ-008 Pipeline SHALL be three stages, all updating only on advance: S1 operand register, S2 mult_res = din*coef (DWIDTH+CWIDTH bits, full signed product), S3 accumulator.
REQ-009 Each stage SHALL carry a valid bit and a last tag; bubbles (in_valid low) propagate as invalid, do not change the accumulator or the term count.
REQ-010 A term counter (0..TERMS-1) SHALL increment on each accepted pair, wrap to 0 after TERMS-1; the pair accepted at count TERMS-1 is tagged last.
REQ-011 S3 on valid non-last: acc <= acc + sign-extended mult_res.
REQ-012 S3 on valid last: result register <= acc + mult_res; acc <= 0; out_valid <= 1; back-to-back blocks SHALL need no idle cycle.
REQ-013 Latency: out_valid SHALL assert after the 3rd advance edge following acceptance of the last term.
REQ-014 out_valid SHALL remain high and dout stable until out_ready is sampled high; out_valid clears on handshake unless a new last term completes in the same cycle, which reloads the register.
REQ-015 While out_valid && !out_ready, the whole pipeline and counter SHALL freeze (no overwrite, no loss).
REQ-016 ena low SHALL freeze all state except out_valid clearing on handshake.
REQ-017 dclr high (with ena) SHALL clear counter, acc, all stage valids and out_valid at the next edge; dclr overrides in_valid in the same cycle (pair discarded).
REQ-018 Accumulator arithmetic SHALL be two's-complement in RWIDTH bits; no internal overflow is possible for in-range inputs.

Reset
REQ-019 rst low SHALL asynchronously clear counter, acc, mult_res, stage valids, result register and out_valid; dout = 0, in_ready follows REQ-007 with out_valid = 0.
REQ-020 Reset release mid-block SHALL leave no partial sum; the next accepted pair is term 0.

Configuration
REQ-021 Macro DCT_MAC_SAT_EN defined: dout SHALL saturate the RWIDTH result to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1].
REQ-022 DCT_MAC_SAT_EN undefined: dout SHALL be the low OWIDTH bits of the RWIDTH result (wrap).

Verification
REQ-023 8 pairs din=1, coef=100, ena=1, out_ready=1, no gaps -> out_valid 3 cycles after 8th pair, dout=800, single-cycle pulse.
REQ-024 8 pairs din=127, coef=32767 -> internal 33291272; dout=2047 with DCT_MAC_SAT_EN, -1016 without.
REQ-025 8 pairs din=-128, coef=100 -> dout=-102400 saturated to -2048 (SAT_EN) / wrap to 0 (no macro); then 8 pairs din=2, coef=-3 back-to-back -> second result -48, no idle cycle.
REQ-026 out_ready=0 at first result, 16 pairs offered -> in_ready drops same cycle out_valid rises; raising out_ready yields both results (800, then next block) in order, none lost.
REQ-027 rst pulsed low after 5 pairs (also dclr after 5 pairs, separately) -> no out_valid; next 8 pairs din=1, coef=100 -> dout=800.
REQ-028 in_valid toggled every other cycle over 8 pairs -> same result as gap-free case; ena low 4 cycles mid-block -> state held, result unchanged.
